// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - fixed-point constants and helpers shared by the convolution MAC
package conv_pkg;

    localparam int DEF_DATA_WIDTH    = 16;
    localparam int DEF_FRACTION_BITS = 14;
    localparam logic signed [DEF_DATA_WIDTH-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DEF_DATA_WIDTH-1:0] Q_MIN = 16'sh8000;

    function automatic int tree_stages(input int n);
        return $clog2(n);
    endfunction

    // Clamp a sign-extended accumulator value into a dw-bit signed range
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] x, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) return hi;
        else if (x < lo) return lo;
        else return x;
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// rtl/conv_adder_tree.sv - registered binary adder tree with valid/tag sideband
module conv_adder_tree
    import conv_pkg::*;
#(
    parameter int N         = 25,
    parameter int ACC_WIDTH = 32,
    parameter int TAG_W     = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        in_valid,
    input  logic [TAG_W-1:0]            in_tag,
    input  logic signed [ACC_WIDTH-1:0] in_data [N],
    output logic                        out_valid,
    output logic [TAG_W-1:0]            out_tag,
    output logic signed [ACC_WIDTH-1:0] out_sum,
    output logic                        busy
);

    localparam int STAGES = tree_stages(N);

    function automatic int lvl_cnt(input int l);
        int c;
        c = N;
        for (int k = 0; k < l; k++) c = (c + 1) / 2;
        return c;
    endfunction

    logic [STAGES-1:0]           r_valid;
    logic [STAGES-1:0]           w_vsrc;
    logic [TAG_W-1:0]            r_tag  [STAGES];
    logic [TAG_W-1:0]            w_tsrc [STAGES];
    logic signed [ACC_WIDTH-1:0] r_lvl  [STAGES][N];
    // Sources are padded to 2N so the pairwise reads never leave the array
    logic signed [ACC_WIDTH-1:0] w_src  [STAGES][2*N];

    always_comb begin
        w_vsrc = '0;
        for (int l = 0; l < STAGES; l++) begin
            w_tsrc[l] = '0;
            for (int i = 0; i < 2 * N; i++) w_src[l][i] = '0;
        end
        w_vsrc[0] = in_valid;
        w_tsrc[0] = in_tag;
        for (int i = 0; i < N; i++) w_src[0][i] = in_data[i];
        for (int l = 1; l < STAGES; l++) begin
            w_vsrc[l] = r_valid[l-1];
            w_tsrc[l] = r_tag[l-1];
            for (int i = 0; i < N; i++) w_src[l][i] = r_lvl[l-1][i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_valid <= '0;
        else if (enable) r_valid <= w_vsrc;
    end

    always_ff @(posedge clock) begin
        if (enable) begin
            for (int l = 0; l < STAGES; l++) begin
                r_tag[l] <= w_tsrc[l];
                for (int i = 0; i < N; i++) begin
                    if (2 * i + 1 < lvl_cnt(l))
                        r_lvl[l][i] <= w_src[l][2*i] + w_src[l][2*i+1];
                    else if (2 * i < lvl_cnt(l))
                        r_lvl[l][i] <= w_src[l][2*i];
                    else
                        r_lvl[l][i] <= '0;
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign out_sum   = r_lvl[STAGES-1][0];
    assign busy      = |r_valid;

endmodule

// File: rtl/pipelined_conv_mac_multichannel.sv
// rtl/pipelined_conv_mac_multichannel.sv - multichannel K*K conv MAC; CONV_RELU_EN fuses ReLU
module pipelined_conv_mac_multichannel
    import conv_pkg::*;
#(
    parameter int KERNEL_SIZE   = 5,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int FRACTION_BITS = DEF_FRACTION_BITS,
    parameter int NUM_CHANNELS  = 1,
    parameter int ACC_WIDTH     = 32
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     enable,
    input  logic                                     in_valid,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] data,
    input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] weights,
    input  logic [DATA_WIDTH-1:0]                    bias,
    output logic                                     out_valid,
    output logic [DATA_WIDTH-1:0]                    convol_out,
    output logic                                     busy
);

    localparam int NT    = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int TAG_W = ACC_WIDTH + 1;

    logic signed [ACC_WIDTH-1:0] w_prod [NT];
    logic signed [ACC_WIDTH-1:0] r_p_prod [NT];
    logic signed [ACC_WIDTH-1:0] r_p_bias;
    logic                        r_p_valid;
    logic                        r_p_last;
    logic [CW-1:0]               r_ch_in;
    logic                        w_last;

    logic                        w_t_valid;
    logic [TAG_W-1:0]            w_t_tag;
    logic signed [ACC_WIDTH-1:0] w_t_sum;
    logic                        w_tree_busy;

    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_acc_valid;
    logic signed [ACC_WIDTH-1:0] w_base;
    logic signed [ACC_WIDTH-1:0] w_total;
    logic [DATA_WIDTH-1:0]       w_sat;
    logic [DATA_WIDTH-1:0]       w_res;
    logic                        r_out_valid;
    logic [DATA_WIDTH-1:0]       r_out;

    always_comb begin
        logic signed [2*DATA_WIDTH-1:0] full;
        full = '0;
        for (int i = 0; i < NT; i++) begin
            full = $signed(data[i*DATA_WIDTH +: DATA_WIDTH]) * $signed(weights[i*DATA_WIDTH +: DATA_WIDTH]);
            w_prod[i] = ACC_WIDTH'(full >>> FRACTION_BITS);
        end
    end

    assign w_last = (r_ch_in == CW'(NUM_CHANNELS - 1));

    conv_adder_tree #(.N(NT), .ACC_WIDTH(ACC_WIDTH), .TAG_W(TAG_W)) u_tree (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .in_valid  (r_p_valid),
        .in_tag    ({r_p_last, r_p_bias}),
        .in_data   (r_p_prod),
        .out_valid (w_t_valid),
        .out_tag   (w_t_tag),
        .out_sum   (w_t_sum),
        .busy      (w_tree_busy)
    );

    // The first channel of a pixel is the beat arriving while no partial is held
    assign w_base  = r_acc_valid ? r_acc : '0;
    assign w_total = w_base + w_t_sum + $signed(w_t_tag[ACC_WIDTH-1:0]);
    assign w_sat   = DATA_WIDTH'(sat_to_width(64'(w_total), DATA_WIDTH));
`ifdef CONV_RELU_EN
    assign w_res   = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
    assign w_res   = w_sat;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_p_valid   <= 1'b0;
            r_p_last    <= 1'b0;
            r_p_bias    <= '0;
            r_ch_in     <= '0;
            r_acc       <= '0;
            r_acc_valid <= 1'b0;
            r_out_valid <= 1'b0;
            r_out       <= '0;
        end else if (enable) begin
            r_p_valid   <= in_valid;
            r_p_prod    <= w_prod;
            r_p_bias    <= ACC_WIDTH'($signed(bias));
            r_p_last    <= w_last;
            if (in_valid) r_ch_in <= w_last ? '0 : r_ch_in + CW'(1);
            r_out_valid <= w_t_valid & w_t_tag[TAG_W-1];
            if (w_t_valid) begin
                if (w_t_tag[TAG_W-1]) begin
                    r_out       <= w_res;
                    r_acc       <= '0;
                    r_acc_valid <= 1'b0;
                end else begin
                    r_acc       <= w_base + w_t_sum;
                    r_acc_valid <= 1'b1;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign convol_out = r_out;
    assign busy       = r_p_valid | w_tree_busy | (r_ch_in != '0) | r_acc_valid;

endmodule

// File: tb/tb_pipelined_conv_mac_multichannel.sv
// tb/tb_pipelined_conv_mac_multichannel.sv - scoreboard bench for 1- and 3-channel MAC instances
module tb_pipelined_conv_mac_multichannel;

    localparam int K  = 5;
    localparam int DW = 16;
    localparam int FB = 14;
    localparam int NT = K * K;
    localparam int LAT_EDGES = 6;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset, enable;
    logic v1, v3;
    logic [DW*NT-1:0] d1, w1, d3, w3;
    logic [DW-1:0] b1, b3;
    logic ov1, ov3, by1, by3;
    logic [DW-1:0] co1, co3;

    pipelined_conv_mac_multichannel #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .FRACTION_BITS(FB),
        .NUM_CHANNELS(1), .ACC_WIDTH(32)) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(v1), .data(d1),
        .weights(w1), .bias(b1), .out_valid(ov1), .convol_out(co1), .busy(by1));

    pipelined_conv_mac_multichannel #(.KERNEL_SIZE(K), .DATA_WIDTH(DW), .FRACTION_BITS(FB),
        .NUM_CHANNELS(3), .ACC_WIDTH(32)) u_dut3 (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(v3), .data(d3),
        .weights(w3), .bias(b3), .out_valid(ov3), .convol_out(co3), .busy(by3));

    typedef struct { logic [DW-1:0] val; int cyc; } exp_t;
    exp_t q1[$];
    exp_t q3[$];

    int checks = 0;
    int failures = 0;
    int ecnt = 0;
    int seen1 = -1, seen3 = -1;
    longint m_acc[2];
    int m_cnt[2];
    logic [DW-1:0] last1 = '0, last3 = '0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic longint dot(input logic [DW*NT-1:0] d, input logic [DW*NT-1:0] w);
        longint s, p;
        s = 0;
        for (int i = 0; i < NT; i++) begin
            p = longint'($signed(d[i*DW +: DW])) * longint'($signed(w[i*DW +: DW]));
            s += p >>> FB;
        end
        return s;
    endfunction

    function automatic logic [DW-1:0] finish_val(input longint s);
        longint r;
        r = s;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`ifdef CONV_RELU_EN
        if (r < 0) r = 0;
`endif
        return DW'(r);
    endfunction

    task automatic model_accept(input int idx, input int nc, input logic [DW*NT-1:0] d,
                                input logic [DW*NT-1:0] w, input logic [DW-1:0] b);
        exp_t e;
        m_acc[idx] += dot(d, w);
        m_cnt[idx]++;
        if (m_cnt[idx] == nc) begin
            e.val = finish_val(m_acc[idx] + longint'($signed(b)));
            e.cyc = ecnt + LAT_EDGES;
            if (idx == 0) q1.push_back(e); else q3.push_back(e);
            m_acc[idx] = 0;
            m_cnt[idx] = 0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) begin
            m_acc[0] = 0; m_acc[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
            q1.delete(); q3.delete();
        end else if (enable) begin
            ecnt++;
            if (v1) model_accept(0, 1, d1, w1, b1);
            if (v3) model_accept(1, 3, d3, w3, b3);
        end
        #1;
    endtask

    task automatic idle(input int n);
        v1 = 0; v3 = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic beat1(input logic [DW-1:0] dv, input logic [DW-1:0] wv, input logic [DW-1:0] bv);
        v1 = 1; d1 = {NT{dv}}; w1 = {NT{wv}}; b1 = bv;
        step();
        v1 = 0;
    endtask

    task automatic beat3(input logic [DW-1:0] dv, input logic [DW-1:0] wv, input logic [DW-1:0] bv);
        v3 = 1; d3 = '0; w3 = '0; d3[DW-1:0] = dv; w3[DW-1:0] = wv; b3 = bv;
        step();
        v3 = 0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (ov1 && ecnt != seen1) begin
            seen1 = ecnt;
            last1 = co1;
            if (q1.size() == 0) check("ch1_unexpected_pulse", 1, 0);
            else begin
                e = q1.pop_front();
                check("ch1_value", co1, e.val);
                check("ch1_latency", ecnt, e.cyc);
            end
        end
        if (ov3 && ecnt != seen3) begin
            seen3 = ecnt;
            last3 = co3;
            if (q3.size() == 0) check("ch3_unexpected_pulse", 1, 0);
            else begin
                e = q3.pop_front();
                check("ch3_value", co3, e.val);
                check("ch3_latency", ecnt, e.cyc);
            end
        end
    end

    initial begin
        int waited;
        reset = 1; enable = 1; v1 = 0; v3 = 0;
        d1 = '0; w1 = '0; d3 = '0; w3 = '0; b1 = '0; b3 = '0;
        m_acc[0] = 0; m_acc[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        step(); step();
        check("rst_out_valid1", ov1, 0); check("rst_convol_out1", co1, 0); check("rst_busy1", by1, 0);
        check("rst_out_valid3", ov3, 0); check("rst_convol_out3", co3, 0); check("rst_busy3", by3, 0);
        reset = 0;

        beat1(16'h4000, 16'h0400, 16'h0000); idle(10);
        check("ch1_unity_sum", last1, 16'h6400);
        beat1(16'h4000, 16'h4000, 16'h0000); idle(10);
        check("ch1_sat_pos", last1, 16'h7FFF);
        beat1(16'h4000, 16'hC000, 16'h0000); idle(10);
`ifdef CONV_RELU_EN
        check("ch1_sat_neg_relu", last1, 16'h0000);
`else
        check("ch1_sat_neg", last1, 16'h8000);
`endif

        beat3(16'h4000, 16'h0400, 16'h0100);
        beat3(16'h4000, 16'h0400, 16'h0100);
        check("ch3_busy_partial", by3, 1);
        beat3(16'h4000, 16'h0400, 16'h0100);
        idle(10);
        check("ch3_three_beats", last3, 16'h0D00);
        check("ch3_busy_idle", by3, 0);

        for (int i = 0; i < 6; i++) beat3(16'h4000, 16'h0400, 16'h0100);
        idle(10);

        for (int i = 0; i < 3; i++) beat3(16'h4000, 16'h0400, 16'h0100);
        idle(2);
        enable = 0; idle(3); enable = 1;
        idle(10);
        check("ch3_after_stall", last3, 16'h0D00);

        beat3(16'h4000, 16'h0400, 16'h0100);
        beat3(16'h4000, 16'h0400, 16'h0100);
        reset = 1; step(); reset = 0;
        check("ch3_busy_after_reset", by3, 0);
        for (int i = 0; i < 3; i++) beat3(16'h4000, 16'h0800, 16'h0100);
        idle(10);
        check("ch3_post_reset", last3, 16'h1900);

        beat1(16'h4000, 16'h0400, 16'h0000);
        waited = 0;
        while (!ov1 && waited < 12) begin step(); waited++; end
        check("freeze_pulse_seen", ov1, 1);
        enable = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("freeze_out_valid", ov1, 1);
            check("freeze_value", co1, 16'h6400);
        end
        enable = 1; step();
        check("freeze_release", ov1, 0);

        for (int c = 0; c < 400; c++) begin
            enable = ($urandom % 8) != 0;
            v1 = ($urandom % 4) != 0;
            v3 = ($urandom % 4) != 0;
            for (int i = 0; i < NT; i++) begin
                d1[i*DW +: DW] = DW'($urandom);
                w1[i*DW +: DW] = DW'($urandom);
                d3[i*DW +: DW] = DW'($urandom);
                w3[i*DW +: DW] = ($urandom % 2) ? DW'($urandom) : DW'($urandom_range(0, 16'h0800));
            end
            b1 = DW'($urandom); b3 = DW'($urandom);
            step();
        end
        // Finish any partial 3-channel pixel so every accepted beat yields an output
        enable = 1; v1 = 0;
        while (m_cnt[1] != 0) beat3(16'h1000, 16'h1000, 16'h0000);
        waited = 0;
        v3 = 0;
        while ((q1.size() != 0 || q3.size() != 0) && waited < 60) begin step(); waited++; end
        idle(2);
        check("drain_q1", q1.size(), 0);
        check("drain_q3", q3.size(), 0);
        check("final_busy1", by1, 0);
        check("final_busy3", by3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
